// File: rtl/trap_controller_if.sv
// ============================================================================
// Module  : trap_controller_if
// Brief   : Trap request, redirect and CSR access bundle for trap_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface trap_controller_if;
    logic        req_valid;
    logic        req_mode;
    logic [31:0] req_cause;
    logic [31:0] req_pc;
    logic [31:0] req_tval;
    logic        req_ready;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        flush_all;
    logic        csr_re;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        mstatus_mie;

    modport master (
        output req_valid, req_mode, req_cause, req_pc, req_tval,
        output csr_re, csr_we, csr_addr, csr_wdata,
        input  req_ready, redir_valid, redir_addr, flush_all,
        input  csr_rdata, csr_illegal, mstatus_mie
    );

    modport slave (
        input  req_valid, req_mode, req_cause, req_pc, req_tval,
        input  csr_re, csr_we, csr_addr, csr_wdata,
        output req_ready, redir_valid, redir_addr, flush_all,
        output csr_rdata, csr_illegal, mstatus_mie
    );
endinterface

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
// Module  : trap_controller
// Brief   : Machine-mode trap entry/return, trap CSRs, PC redirect and flush drain.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module trap_controller #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter bit          VECTORED_EN  = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    trap_controller_if.slave bus
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL   = 12'h343;
    localparam logic [3:0]  c_DRAIN_LOAD   = 4'(DRAIN_CYCLES - 1);
    localparam logic        c_RESET_MODE   = VECTORED_EN && (RESET_MTVEC[1:0] == 2'b01);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_redir_valid;
    logic [31:0] r_redir_addr;
    logic        r_flush;

    logic        r_mie;
    logic        r_mpie;
    logic [29:0] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic        w_vec_ok;
    logic        w_accept;
    logic        w_enter;
    logic        w_return;
    logic [31:0] w_enter_target;
    logic [31:0] w_mstatus;
    logic        w_hit_mstatus;
    logic        w_hit_mtvec;
    logic        w_hit_mepc;
    logic        w_hit_mcause;
    logic        w_hit_mtval;
    logic        w_known;
    logic [31:0] w_rdata;

    generate
        if (VECTORED_EN) begin : g_vectored
            assign w_vec_ok = 1'b1;
        end else begin : g_direct_only
            assign w_vec_ok = 1'b0;
        end
    endgenerate

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    assign w_enter  = w_accept && !bus.req_mode;
    assign w_return = w_accept &&  bus.req_mode;

    // Vectored mode only offsets interrupts; exceptions always land on BASE.
    assign w_enter_target = (r_mtvec_mode && bus.req_cause[31])
                          ? {r_mtvec_base, 2'b00} + {bus.req_cause[29:0], 2'b00}
                          : {r_mtvec_base, 2'b00};

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    assign w_hit_mstatus = (bus.csr_addr == c_ADDR_MSTATUS);
    assign w_hit_mtvec   = (bus.csr_addr == c_ADDR_MTVEC);
    assign w_hit_mepc    = (bus.csr_addr == c_ADDR_MEPC);
    assign w_hit_mcause  = (bus.csr_addr == c_ADDR_MCAUSE);
    assign w_hit_mtval   = (bus.csr_addr == c_ADDR_MTVAL);
    assign w_known       = w_hit_mstatus | w_hit_mtvec | w_hit_mepc | w_hit_mcause | w_hit_mtval;

    always_comb begin
        w_rdata = 32'd0;
        if (bus.csr_re) begin
            unique case (1'b1)
                w_hit_mstatus: w_rdata = w_mstatus;
                w_hit_mtvec:   w_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
                w_hit_mepc:    w_rdata = r_mepc;
                w_hit_mcause:  w_rdata = r_mcause;
                w_hit_mtval:   w_rdata = r_mtval;
                default:       w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.csr_rdata   = w_rdata;
    assign bus.csr_illegal = (bus.csr_re || bus.csr_we) && !w_known;
    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.redir_valid = r_redir_valid;
    assign bus.redir_addr  = r_redir_addr;
    assign bus.flush_all   = r_flush;
    assign bus.mstatus_mie = r_mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_redir_valid <= 1'b0;
            r_redir_addr  <= 32'd0;
            r_flush       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_REDIRECT;
                        r_redir_valid <= 1'b1;
                        r_flush       <= 1'b1;
                        r_redir_addr  <= bus.req_mode ? r_mepc : w_enter_target;
                    end
                end
                ST_REDIRECT: begin
                    r_state       <= ST_DRAIN;
                    r_redir_valid <= 1'b0;
                    r_cnt         <= c_DRAIN_LOAD;
                end
                ST_DRAIN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_redir_valid <= 1'b0;
                    r_flush       <= 1'b0;
                end
            endcase
        end
    end

    // Trap updates are assigned after the CSR writes so they take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_mtvec_base <= RESET_MTVEC[31:2];
            r_mtvec_mode <= c_RESET_MODE;
            r_mepc       <= 32'd0;
            r_mcause     <= 32'd0;
            r_mtval      <= 32'd0;
        end else begin
            if (bus.csr_we && w_hit_mstatus) begin
                r_mie  <= bus.csr_wdata[3];
                r_mpie <= bus.csr_wdata[7];
            end
            if (bus.csr_we && w_hit_mtvec) begin
                r_mtvec_base <= bus.csr_wdata[31:2];
                r_mtvec_mode <= w_vec_ok && (bus.csr_wdata[1:0] == 2'b01);
            end
            if (bus.csr_we && w_hit_mepc)   r_mepc   <= {bus.csr_wdata[31:2], 2'b00};
            if (bus.csr_we && w_hit_mcause) r_mcause <= bus.csr_wdata;
            if (bus.csr_we && w_hit_mtval)  r_mtval  <= bus.csr_wdata;

            if (w_enter) begin
                r_mepc   <= {bus.req_pc[31:2], 2'b00};
                r_mcause <= bus.req_cause;
                r_mtval  <= bus.req_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_return) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
// ============================================================================
// Module  : tb_trap_controller
// Brief   : Directed self-checking bench for trap_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trap_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    trap_controller_if bus();

    trap_controller #(
        .RESET_MTVEC (32'h0000_0100),
        .DRAIN_CYCLES(2),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        bus.csr_addr = a;
        bus.csr_re   = 1'b1;
        #1;
        d = bus.csr_rdata;
        bus.csr_re = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        bus.csr_we    = 1'b1;
        tick();
        bus.csr_we = 1'b0;
    endtask

    // Presents one request for a single accept edge; returns in the REDIRECT cycle.
    task automatic issue(input logic mode, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval);
        for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_wait_ready: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_mode  = mode;
        bus.req_cause = cause;
        bus.req_pc    = pc;
        bus.req_tval  = tval;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.redir_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid: got %b want 0", bus.redir_valid); end
        checks++; if (bus.redir_addr !== 32'h0) begin errors++; $display("FAIL reset_redir_addr: got %h want 0", bus.redir_addr); end
        checks++; if (bus.flush_all !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush_all); end
        checks++; if (bus.mstatus_mie !== 1'b0) begin errors++; $display("FAIL reset_mie: got %b want 0", bus.mstatus_mie); end
        checks++; if (bus.csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_idle: got %h want 0", bus.csr_rdata); end
        csr_read(A_MTVEC, d);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL reset_mtvec: got %h want 00000100", d); end
        csr_read(A_MSTATUS, d);
        checks++; if (d !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h want 00001800", d); end
        csr_read(A_MEPC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h want 0", d); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_enter_basic();
        logic [31:0] d;
        int n_flush, n_busy, n_redir;
        issue(1'b0, 32'd2, 32'h44, 32'h13);
        checks++; if (bus.redir_valid !== 1'b1) begin errors++; $display("FAIL enter_redir_valid: got %b want 1", bus.redir_valid); end
        checks++; if (bus.redir_addr !== 32'h100) begin errors++; $display("FAIL enter_redir_addr: got %h want 00000100", bus.redir_addr); end
        checks++; if (bus.mstatus_mie !== 1'b0) begin errors++; $display("FAIL enter_mie: got %b want 0", bus.mstatus_mie); end
        csr_read(A_MEPC, d);
        checks++; if (d !== 32'h44) begin errors++; $display("FAIL enter_mepc: got %h want 00000044", d); end
        csr_read(A_MCAUSE, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL enter_mcause: got %h want 00000002", d); end
        n_flush = int'(bus.flush_all);
        n_busy  = int'(!bus.req_ready);
        n_redir = int'(bus.redir_valid);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_flush += int'(bus.flush_all);
            n_busy  += int'(!bus.req_ready);
            n_redir += int'(bus.redir_valid);
        end
        checks++; if (n_flush != 3) begin errors++; $display("FAIL enter_flush_cycles: got %0d want 3", n_flush); end
        checks++; if (n_busy != 3) begin errors++; $display("FAIL enter_busy_cycles: got %0d want 3", n_busy); end
        checks++; if (n_redir != 1) begin errors++; $display("FAIL enter_redir_pulses: got %0d want 1", n_redir); end
        csr_read(A_MTVAL, d);
        checks++; if (d !== 32'h13) begin errors++; $display("FAIL enter_mtval: got %h want 00000013", d); end
    endtask

    task automatic test_vectored();
        logic [31:0] d;
        csr_write(A_MTVEC, 32'h0000_0201);
        csr_write(A_MSTATUS, 32'h0000_0008);
        csr_read(A_MTVEC, d);
        checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL vec_mtvec_rd: got %h want 00000201", d); end
        checks++; if (bus.mstatus_mie !== 1'b1) begin errors++; $display("FAIL vec_mie_set: got %b want 1", bus.mstatus_mie); end
        issue(1'b0, 32'h8000_0007, 32'h80, 32'h0);
        checks++; if (bus.redir_addr !== 32'h21C) begin errors++; $display("FAIL vec_irq_addr: got %h want 0000021c", bus.redir_addr); end
        csr_read(A_MSTATUS, d);
        checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL vec_mstatus: got %h want 00001880", d); end
        repeat (4) tick();
        issue(1'b0, 32'd5, 32'h84, 32'h0);
        checks++; if (bus.redir_addr !== 32'h200) begin errors++; $display("FAIL vec_exc_addr: got %h want 00000200", bus.redir_addr); end
        repeat (4) tick();
        csr_write(A_MTVEC, 32'h0000_0203);
        csr_read(A_MTVEC, d);
        checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL vec_warl_mode3: got %h want 00000200", d); end
        csr_write(A_MTVEC, 32'h0000_0100);
    endtask

    task automatic test_misaligned_mret();
        logic [31:0] d;
        csr_write(A_MSTATUS, 32'h0000_0008);
        issue(1'b0, 32'd0, 32'h1002, 32'h1002);
        csr_read(A_MEPC, d);
        checks++; if (d !== 32'h1000) begin errors++; $display("FAIL mis_mepc: got %h want 00001000", d); end
        checks++; if (bus.mstatus_mie !== 1'b0) begin errors++; $display("FAIL mis_mie_cleared: got %b want 0", bus.mstatus_mie); end
        repeat (4) tick();
        issue(1'b1, 32'h0, 32'h0, 32'h0);
        checks++; if (bus.redir_valid !== 1'b1) begin errors++; $display("FAIL mret_redir_valid: got %b want 1", bus.redir_valid); end
        checks++; if (bus.redir_addr !== 32'h1000) begin errors++; $display("FAIL mret_addr: got %h want 00001000", bus.redir_addr); end
        checks++; if (bus.mstatus_mie !== 1'b1) begin errors++; $display("FAIL mret_mie: got %b want 1", bus.mstatus_mie); end
        csr_read(A_MSTATUS, d);
        checks++; if (d !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus: got %h want 00001888", d); end
        repeat (4) tick();
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int extra;
        bit got_ready;
        bus.req_valid = 1'b1; bus.req_mode = 1'b0;
        bus.req_cause = 32'hB; bus.req_pc = 32'h500; bus.req_tval = 32'h0;
        bus.csr_we = 1'b1; bus.csr_addr = A_MEPC; bus.csr_wdata = 32'hABC;
        tick();
        bus.csr_we = 1'b0;
        bus.req_cause = 32'h9; bus.req_pc = 32'h900;
        csr_read(A_MEPC, d);
        checks++; if (d !== 32'h500) begin errors++; $display("FAIL coll_mepc: got %h want 00000500", d); end
        extra = 0;
        got_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            extra += int'(bus.redir_valid);
            if (bus.req_ready) begin
                bus.req_valid = 1'b0;
                got_ready = 1'b1;
                break;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (extra != 0) begin errors++; $display("FAIL drain_ignore_redir: got %0d want 0", extra); end
        checks++; if (got_ready !== 1'b1) begin errors++; $display("FAIL drain_timeout: ready=%b want 1", got_ready); end
        csr_read(A_MCAUSE, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL drain_mcause: got %h want 0000000b", d); end
        tick();
        bus.csr_we = 1'b1; bus.csr_addr = A_MTVEC; bus.csr_wdata = 32'h300;
        issue(1'b0, 32'd4, 32'h600, 32'h0);
        bus.csr_we = 1'b0;
        checks++; if (bus.redir_addr !== 32'h100) begin errors++; $display("FAIL coll_mtvec_old: got %h want 00000100", bus.redir_addr); end
        csr_read(A_MTVEC, d);
        checks++; if (d !== 32'h300) begin errors++; $display("FAIL coll_mtvec_new: got %h want 00000300", d); end
        repeat (4) tick();
    endtask

    task automatic test_reset_midflow();
        logic [31:0] d;
        issue(1'b0, 32'd3, 32'h60, 32'h0);
        tick();
        checks++; if (bus.flush_all !== 1'b1) begin errors++; $display("FAIL drain_flush_pre: got %b want 1", bus.flush_all); end
        rst = 1'b1;
        #1;
        checks++; if (bus.flush_all !== 1'b0) begin errors++; $display("FAIL rst_drain_flush: got %b want 0", bus.flush_all); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_ready: got %b want 1", bus.req_ready); end
        tick();
        rst = 1'b0;
        tick();
        issue(1'b0, 32'd3, 32'h64, 32'h0);
        rst = 1'b1;
        #1;
        checks++; if (bus.redir_valid !== 1'b0) begin errors++; $display("FAIL rst_redir_pulse: got %b want 0", bus.redir_valid); end
        checks++; if (bus.redir_addr !== 32'h0) begin errors++; $display("FAIL rst_redir_addr: got %h want 0", bus.redir_addr); end
        tick();
        rst = 1'b0;
        tick();
        bus.csr_addr = 12'h7C0; bus.csr_re = 1'b1;
        #1;
        checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", bus.csr_illegal); end
        checks++; if (bus.csr_rdata !== 32'h0) begin errors++; $display("FAIL illegal_rdata: got %h want 0", bus.csr_rdata); end
        bus.csr_addr = A_MEPC;
        #1;
        checks++; if (bus.csr_illegal !== 1'b0) begin errors++; $display("FAIL legal_flag: got %b want 0", bus.csr_illegal); end
        bus.csr_re = 1'b0;
        tick();
        csr_write(A_MEPC, 32'h123);
        csr_read(A_MEPC, d);
        checks++; if (d !== 32'h120) begin errors++; $display("FAIL mepc_align: got %h want 00000120", d); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_mode = 1'b0;
        bus.req_cause = 32'h0; bus.req_pc = 32'h0; bus.req_tval = 32'h0;
        bus.csr_re = 1'b0; bus.csr_we = 1'b0;
        bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0;
        test_reset();
        test_enter_basic();
        test_vectored();
        test_misaligned_mret();
        test_collision();
        test_reset_midflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
